uart_stim_tx: RTL and testbench



---
 rtl/uart_stim_pkg.sv | 24 ++
 rtl/uart_stim_tx_fifo.sv | 61 ++++++
 rtl/uart_stim_tx.sv | 171 +++++++++++++++++
 tb/tb_uart_stim_tx.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_stim_pkg.sv
// Shared types and helpers for the uart_stim_tx serial frame generator.
// frame_cycles() gives the start-to-start spacing of back-to-back frames.
package uart_stim_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_GAP,
    ST_BREAK
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_cycles(input int cpb, input int dataBits, input int parity,
                                      input int stopBits, input int gapBits);
    return cpb * (1 + dataBits + ((parity != PAR_NONE) ? 1 : 0) + stopBits + gapBits) + 1;
  endfunction

endpackage

// File: rtl/uart_stim_tx_fifo.sv
// Synchronous FIFO with registered full/level; a push while full is dropped
// unless a pop happens in the same cycle.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_LEVEL = (PTR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic              w_doPush;
  logic              w_doPop;
  logic [PTR_W:0]    w_levelNext;

  assign w_doPop  = i_pop && (o_level != '0);
  assign w_doPush = i_push && (!o_full || w_doPop);
  assign o_head   = r_mem[r_rdPtr];

  always_comb begin
    w_levelNext = o_level;
    if (w_doPush && !w_doPop)
      w_levelNext = o_level + 1'b1;
    else if (!w_doPush && w_doPop)
      w_levelNext = o_level - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (w_doPush)
      r_mem[r_wrPtr] <= i_data;
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      o_level <= '0;
      o_full  <= 1'b0;
    end else begin
      if (w_doPush)
        r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)
        r_rdPtr <= r_rdPtr + 1'b1;
      o_level <= w_levelNext;
      o_full  <= (w_levelNext == FULL_LEVEL);
    end
  end

endmodule

// File: rtl/uart_stim_tx.sv
// FIFO-fed asynchronous serial transmitter with configurable frame format
// and a line-break mode; all outputs are registered.
module uart_stim_tx
  import uart_stim_pkg::*;
#(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int GAP_BITS     = 0,
  parameter int BREAK_BITS   = 12,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  input  logic                          break_req,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]       DATA_LAST  = 16'(DATA_BITS - 1);
  localparam logic [15:0]       STOP_LAST  = 16'(STOP_BITS - 1);
  localparam logic [15:0]       GAP_LAST   = 16'(GAP_BITS - 1);
  localparam logic [15:0]       BREAK_LAST = 16'(BREAK_BITS - 1);
  localparam bit                HAS_PAR    = (PARITY != PAR_NONE);
  localparam bit                HAS_GAP    = (GAP_BITS > 0);

  state_t                r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [15:0]           r_bitCnt;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_parity;
  logic [DATA_BITS-1:0]  w_head;
  logic                  w_pop;
  logic                  w_bitEnd;
  logic                  w_parBit;

  // Pop only when IDLE actually launches a frame; break wins over data.
  assign w_pop    = (r_state == ST_IDLE) && !break_req && (level != '0);
  assign w_bitEnd = (r_baud == BAUD_LAST);
  assign w_parBit = (PARITY == PAR_EVEN) ? r_parity : ~r_parity;

  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (wr_en),
    .i_data  (wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (full),
    .o_level (level)
  );

  // tx is always loaded with the value of the bit being entered, so the
  // line changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_baud   <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      r_baud <= (r_state == ST_IDLE || w_bitEnd) ? '0 : r_baud + 1'b1;
      case (r_state)
        ST_IDLE: begin
          r_bitCnt <= '0;
          if (break_req) begin
            r_state <= ST_BREAK;
            tx      <= 1'b0;
            busy    <= 1'b1;
          end else if (level != '0) begin
            r_state  <= ST_START;
            r_shift  <= w_head;
            r_parity <= ^w_head;
            tx       <= 1'b0;
            busy     <= 1'b1;
          end else begin
            tx   <= 1'b1;
            busy <= 1'b0;
          end
        end
        ST_START: begin
          if (w_bitEnd) begin
            r_state <= ST_DATA;
            tx      <= r_shift[0];
          end
        end
        ST_DATA: begin
          if (w_bitEnd) begin
            if (r_bitCnt == DATA_LAST) begin
              r_bitCnt <= '0;
              if (HAS_PAR) begin
                r_state <= ST_PAR;
                tx      <= w_parBit;
              end else begin
                r_state <= ST_STOP;
                tx      <= 1'b1;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 16'd1;
              r_shift  <= r_shift >> 1;
              tx       <= r_shift[1];
            end
          end
        end
        ST_PAR: begin
          if (w_bitEnd) begin
            r_state <= ST_STOP;
            tx      <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_bitEnd) begin
            if (r_bitCnt == STOP_LAST) begin
              r_bitCnt <= '0;
              tx       <= 1'b1;
              if (HAS_GAP) begin
                r_state <= ST_GAP;
              end else begin
                r_state <= ST_IDLE;
                busy    <= 1'b0;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 16'd1;
            end
          end
        end
        ST_GAP: begin
          if (w_bitEnd) begin
            if (r_bitCnt == GAP_LAST) begin
              r_bitCnt <= '0;
              r_state  <= ST_IDLE;
              busy     <= 1'b0;
            end else begin
              r_bitCnt <= r_bitCnt + 16'd1;
            end
          end
        end
        ST_BREAK: begin
          if (w_bitEnd) begin
            if (r_bitCnt == BREAK_LAST) begin
              r_bitCnt <= '0;
              r_state  <= ST_STOP;
              tx       <= 1'b1;
            end else begin
              r_bitCnt <= r_bitCnt + 16'd1;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          tx      <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Directed bench for uart_stim_tx: five instances with different frame
// formats, all at 4 clocks per bit, driven from one linear sequence.
module tb_uart_stim_tx;
  import uart_stim_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic noBreak = 1'b0;

  logic       wrEnA, breakA, fullA, busyA, txA;
  logic [7:0] wrDataA;
  logic [4:0] levelA;
  logic       wrEnB, fullB, busyB, txB;
  logic [6:0] wrDataB;
  logic [4:0] levelB;
  logic       wrEnC, fullC, busyC, txC;
  logic [6:0] wrDataC;
  logic [4:0] levelC;
  logic       wrEnD, fullD, busyD, txD;
  logic [7:0] wrDataD;
  logic [2:0] levelD;
  logic       wrEnE, fullE, busyE, txE;
  logic [7:0] wrDataE;
  logic [4:0] levelE;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_stim_tx #(.CLKS_PER_BIT(4)) uA (
    .clk(clk), .reset(reset), .wr_en(wrEnA), .wr_data(wrDataA), .break_req(breakA),
    .full(fullA), .level(levelA), .busy(busyA), .tx(txA));

  uart_stim_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(PAR_EVEN)) uB (
    .clk(clk), .reset(reset), .wr_en(wrEnB), .wr_data(wrDataB), .break_req(noBreak),
    .full(fullB), .level(levelB), .busy(busyB), .tx(txB));

  uart_stim_tx #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(PAR_ODD)) uC (
    .clk(clk), .reset(reset), .wr_en(wrEnC), .wr_data(wrDataC), .break_req(noBreak),
    .full(fullC), .level(levelC), .busy(busyC), .tx(txC));

  uart_stim_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) uD (
    .clk(clk), .reset(reset), .wr_en(wrEnD), .wr_data(wrDataD), .break_req(noBreak),
    .full(fullD), .level(levelD), .busy(busyD), .tx(txD));

  uart_stim_tx #(.CLKS_PER_BIT(4), .STOP_BITS(2), .GAP_BITS(3)) uE (
    .clk(clk), .reset(reset), .wr_en(wrEnE), .wr_data(wrDataE), .break_req(noBreak),
    .full(fullE), .level(levelE), .busy(busyE), .tx(txE));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic getTx(input int sel);
    case (sel)
      0: return txA;
      1: return txB;
      2: return txC;
      3: return txD;
      default: return txE;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle push into the selected instance; back-to-back calls push on consecutive edges.
  task automatic applyStimulus(input int sel, input logic [7:0] data);
    case (sel)
      0: begin wrEnA = 1'b1; wrDataA = data; end
      1: begin wrEnB = 1'b1; wrDataB = data[6:0]; end
      2: begin wrEnC = 1'b1; wrDataC = data[6:0]; end
      3: begin wrEnD = 1'b1; wrDataD = data; end
      default: begin wrEnE = 1'b1; wrDataE = data; end
    endcase
    tick();
    wrEnA = 1'b0; wrEnB = 1'b0; wrEnC = 1'b0; wrEnD = 1'b0; wrEnE = 1'b0;
  endtask

  // Samples each bit at its middle; startOff < 0 means first wait for the start bit.
  task automatic decodeFrame(input int sel, input string tag, input int nBits, input bit hasPar,
                             input int startOff, output logic [8:0] data, output logic par);
    int off;
    int waitCnt;
    int t;
    data = '0;
    par  = 1'b0;
    if (startOff < 0) begin
      waitCnt = 0;
      while (getTx(sel) !== 1'b0 && waitCnt < 300) begin
        tick();
        waitCnt++;
      end
      checkOutput($sformatf("%s_syncInTime", tag), 32'(waitCnt < 300), 32'd1);
      off = 0;
    end else begin
      off = startOff;
    end
    if (off <= 2) begin
      repeat (2 - off) tick();
      off = 2;
      checkOutput($sformatf("%s_start", tag), 32'(getTx(sel)), 32'd0);
    end
    for (int k = 0; k < nBits; k++) begin
      t = 4 * (1 + k) + 2;
      repeat (t - off) tick();
      off = t;
      data[k] = getTx(sel);
    end
    if (hasPar) begin
      t = 4 * (1 + nBits) + 2;
      repeat (t - off) tick();
      off = t;
      par = getTx(sel);
    end
    t = 4 * (1 + nBits + (hasPar ? 1 : 0)) + 2;
    repeat (t - off) tick();
    checkOutput($sformatf("%s_stop", tag), 32'(getTx(sel)), 32'd1);
  endtask

  initial begin
    logic [9:0] frame41;
    logic [8:0] d;
    logic       p;
    int         n;
    int         t0;
    int         lowSeen;

    reset = 1'b1;
    wrEnA = 1'b0; wrEnB = 1'b0; wrEnC = 1'b0; wrEnD = 1'b0; wrEnE = 1'b0;
    wrDataA = '0; wrDataB = '0; wrDataC = '0; wrDataD = '0; wrDataE = '0;
    breakA = 1'b0;
    repeat (2) tick();
    checkOutput("rst_tx", 32'(txA), 32'd1);
    checkOutput("rst_busy", 32'(busyA), 32'd0);
    checkOutput("rst_full", 32'(fullA), 32'd0);
    checkOutput("rst_level", 32'(levelA), 32'd0);
    reset = 1'b0;
    tick();

    // 0x41 on default format: start, 1,0,0,0,0,0,1,0, stop at 4 cycles each.
    frame41 = 10'b1_0100_0001_0;
    applyStimulus(0, 8'h41);
    checkOutput("t1_levelAfterPush", 32'(levelA), 32'd1);
    checkOutput("t1_txStillIdle", 32'(txA), 32'd1);
    tick();
    checkOutput("t1_popLevel", 32'(levelA), 32'd0);
    checkOutput("t1_busyUp", 32'(busyA), 32'd1);
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t1_bit%0dFirst", k), 32'(txA), 32'(frame41[k]));
      repeat (3) tick();
      checkOutput($sformatf("t1_bit%0dLast", k), 32'(txA), 32'(frame41[k]));
      if (k == 9) checkOutput("t1_busyLastCycle", 32'(busyA), 32'd1);
      tick();
    end
    checkOutput("t1_busyDropAt40", 32'(busyA), 32'd0);
    checkOutput("t1_txIdle", 32'(txA), 32'd1);

    // 7-bit 0x55 has four ones: even parity bit 0, odd parity bit 1.
    applyStimulus(1, 8'h55);
    decodeFrame(1, "t2even", 7, 1'b1, -1, d, p);
    checkOutput("t2even_data", 32'(d), 32'h55);
    checkOutput("t2even_par", 32'(p), 32'd0);
    applyStimulus(2, 8'h55);
    decodeFrame(2, "t2odd", 7, 1'b1, -1, d, p);
    checkOutput("t2odd_data", 32'(d), 32'h55);
    checkOutput("t2odd_par", 32'(p), 32'd1);

    // Depth-4 FIFO: six pushes, first popped at once, sixth dropped.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(3, 8'(8'h10 + i));
      if (i == 3) begin
        checkOutput("t3_level4th", 32'(levelD), 32'd3);
        checkOutput("t3_full4th", 32'(fullD), 32'd0);
      end
      if (i == 4) begin
        checkOutput("t3_level5th", 32'(levelD), 32'd4);
        checkOutput("t3_full5th", 32'(fullD), 32'd1);
      end
    end
    checkOutput("t3_levelAfterDrop", 32'(levelD), 32'd4);
    checkOutput("t3_fullAfterDrop", 32'(fullD), 32'd1);
    decodeFrame(3, "t3f0", 8, 1'b0, 4, d, p);
    checkOutput("t3f0_data", 32'(d), 32'h10);
    for (int f = 1; f < 5; f++) begin
      decodeFrame(3, $sformatf("t3f%0d", f), 8, 1'b0, -1, d, p);
      checkOutput($sformatf("t3f%0d_data", f), 32'(d), 32'(8'h10 + f));
    end
    checkOutput("t3_levelEmpty", 32'(levelD), 32'd0);
    lowSeen = 0;
    repeat (100) begin
      tick();
      if (txD !== 1'b1) lowSeen++;
    end
    checkOutput("t3_noSixthFrame", 32'(lowSeen), 32'd0);

    // Two stop bits and three gap bits: starts 4*(1+8+2+3)+1 = 57 cycles apart.
    applyStimulus(4, 8'hA5);
    applyStimulus(4, 8'h3C);
    checkOutput("t4_firstStart", 32'(txE), 32'd0);
    t0 = cyc;
    n = 0;
    while (busyE !== 1'b0 && n < 200) begin tick(); n++; end
    while (txE !== 1'b0 && n < 200) begin tick(); n++; end
    checkOutput("t4_secondStartInTime", 32'(n < 200), 32'd1);
    checkOutput("t4_startSpacing", 32'(cyc - t0), 32'(frame_cycles(4, 8, PAR_NONE, 2, 3)));
    decodeFrame(4, "t4f1", 8, 1'b0, 0, d, p);
    checkOutput("t4f1_data", 32'(d), 32'h3C);

    // Break raised mid-frame waits for IDLE, then beats the queued byte.
    applyStimulus(0, 8'h5A);
    applyStimulus(0, 8'hC3);
    breakA = 1'b1;
    decodeFrame(0, "t5f0", 8, 1'b0, 0, d, p);
    checkOutput("t5f0_data", 32'(d), 32'h5A);
    n = 0;
    while (txA !== 1'b0 && n < 200) begin tick(); n++; end
    breakA = 1'b0;
    checkOutput("t5_breakInTime", 32'(n < 200), 32'd1);
    checkOutput("t5_byteStillQueued", 32'(levelA), 32'd1);
    n = 0;
    while (txA === 1'b0 && n < 200) begin tick(); n++; end
    checkOutput("t5_breakLowCycles", 32'(n), 32'd48);
    n = 0;
    while (txA === 1'b1 && n < 200) begin tick(); n++; end
    checkOutput("t5_stopPlusIdleHigh", 32'(n), 32'd5);
    decodeFrame(0, "t5f1", 8, 1'b0, 0, d, p);
    checkOutput("t5f1_data", 32'(d), 32'hC3);

    // Reset during DATA with three bytes queued.
    n = 0;
    while ((busyA !== 1'b0 || levelA !== 5'd0) && n < 200) begin tick(); n++; end
    checkOutput("t6_idleBeforePush", 32'(n < 200), 32'd1);
    applyStimulus(0, 8'h11);
    applyStimulus(0, 8'h22);
    applyStimulus(0, 8'h33);
    applyStimulus(0, 8'h44);
    checkOutput("t6_levelQueued", 32'(levelA), 32'd3);
    repeat (8) tick();
    checkOutput("t6_busyMidData", 32'(busyA), 32'd1);
    reset = 1'b1;
    tick();
    checkOutput("t6_txAfterReset", 32'(txA), 32'd1);
    checkOutput("t6_levelAfterReset", 32'(levelA), 32'd0);
    checkOutput("t6_busyAfterReset", 32'(busyA), 32'd0);
    checkOutput("t6_fullAfterReset", 32'(fullA), 32'd0);
    reset = 1'b0;
    lowSeen = 0;
    repeat (100) begin
      tick();
      if (txA !== 1'b1 || busyA !== 1'b0) lowSeen++;
    end
    checkOutput("t6_noFrameAfterReset", 32'(lowSeen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
